// File: rtl/imem_pkg.sv
// Shared constants for the pipelined instruction memory: NOP encoding,
// legal fetch-latency range and the address-decode field positions.
package imem_pkg;

  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 3;

  localparam int unsigned NOP_W    = 64;
  localparam logic [NOP_W-1:0] NOP_WORD = '0;

  localparam int unsigned BYTE_OFS_W = 2;
  localparam int unsigned ADDR_IN_W  = 32;

  // Bit position where the word index starts inside a fetch address.
  function automatic int unsigned index_lsb(input int unsigned byte_addr);
    return (byte_addr != 0) ? BYTE_OFS_W : 0;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage with one registered read-first port and one write port.
// Contents survive reset; only the read register is cleared.
module imem_array
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 11,
  parameter              INIT_FILE = "mips_hex_program.hex"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_idx,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_d;
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  // Read samples the array before the same-edge write lands (read-first).
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instruction_memory_pipelined.sv
// Pipelined instruction fetch: address decode, error flagging, stall-frozen
// stages and a 1..3 cycle fetch latency wrapped around imem_array.
module instruction_memory_pipelined
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned BYTE_ADDR = 1,
  parameter              INIT_FILE = "mips_hex_program.hex"
) (
  input  logic                 in_clk,
  input  logic                 in_reset_n,
  input  logic                 in_req,
  input  logic [ADDR_IN_W-1:0] in_addr,
  input  logic                 in_stall,
  output logic                 out_req_ready,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_instruction,
  output logic                 out_error,
  input  logic                 in_load_en,
  input  logic [ADDR_IN_W-1:0] in_load_addr,
  input  logic [DATA_W-1:0]    in_load_data
);

  localparam int unsigned IDX_LSB = index_lsb(BYTE_ADDR);
  localparam int unsigned TOP_LSB = IDX_LSB + ADDR_W;

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("instruction_memory_pipelined: LATENCY must be within 1..3");
  end

  logic              accept;
  logic              misaligned;
  logic              out_of_range;
  logic              fetch_err;
  logic [ADDR_W-1:0] fetch_idx;
  logic              load_in_range;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] s1_data;
  logic              s1_valid_d, s1_valid_q;
  logic              s1_err_d, s1_err_q;

  assign out_req_ready = !in_stall;
  assign accept        = in_req && !in_stall;
  assign fetch_idx     = in_addr[IDX_LSB +: ADDR_W];
  assign misaligned    = (BYTE_ADDR != 0) && (in_addr[BYTE_OFS_W-1:0] != '0);
  assign out_of_range  = (in_addr >> TOP_LSB) != '0;
  assign fetch_err     = misaligned || out_of_range;
  assign load_in_range = (in_load_addr >> ADDR_W) == '0;

  imem_array #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_array (
    .clk    (in_clk),
    .rst_n  (in_reset_n),
    .rd_en  (accept),
    .rd_idx (fetch_idx),
    .rd_data(rd_data),
    .wr_en  (in_load_en && load_in_range),
    .wr_idx (in_load_addr[ADDR_W-1:0]),
    .wr_data(in_load_data)
  );

  // Stage 1 rides alongside the array read register; error only moves on accept
  // so the masked word holds through bubbles and stalls.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_err_d   = s1_err_q;
    if (!in_stall) s1_valid_d = accept;
    if (accept)    s1_err_d   = fetch_err;
  end

  always_ff @(posedge in_clk or negedge in_reset_n) begin
    if (!in_reset_n) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
    end
  end

  assign s1_data = s1_err_q ? DATA_W'(NOP_WORD) : rd_data;

  if (LATENCY <= 1) begin : g_single_stage
    assign out_valid       = s1_valid_q;
    assign out_error       = s1_err_q;
    assign out_instruction = s1_data;
  end else begin : g_extra_stages
    localparam int unsigned EXTRA = LATENCY - 1;

    logic              valid_d [EXTRA];
    logic              valid_q [EXTRA];
    logic              err_d   [EXTRA];
    logic              err_q   [EXTRA];
    logic [DATA_W-1:0] data_d  [EXTRA];
    logic [DATA_W-1:0] data_q  [EXTRA];

    // Payload only advances behind a valid entry, so bubbles keep the last word.
    always_comb begin
      valid_d = valid_q;
      err_d   = err_q;
      data_d  = data_q;
      if (!in_stall) begin
        valid_d[0] = s1_valid_q;
        if (s1_valid_q) begin
          err_d[0]  = s1_err_q;
          data_d[0] = s1_data;
        end
        for (int k = 1; k < EXTRA; k++) begin
          valid_d[k] = valid_q[k-1];
          if (valid_q[k-1]) begin
            err_d[k]  = err_q[k-1];
            data_d[k] = data_q[k-1];
          end
        end
      end
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
        for (int k = 0; k < EXTRA; k++) begin
          valid_q[k] <= 1'b0;
          err_q[k]   <= 1'b0;
          data_q[k]  <= '0;
        end
      end else begin
        valid_q <= valid_d;
        err_q   <= err_d;
        data_q  <= data_d;
      end
    end

    assign out_valid       = valid_q[EXTRA-1];
    assign out_error       = err_q[EXTRA-1];
    assign out_instruction = data_q[EXTRA-1];
  end

endmodule

// File: tb/tb_instruction_memory_pipelined.sv
// Scoreboard bench driving three instruction memories (LATENCY 1, 2, 3) in
// lockstep against a word-array reference model.
module tb_instruction_memory_pipelined;

  localparam int NLAT      = 3;
  localparam int ADDR_W    = 11;
  localparam int DEPTH     = 2 ** ADDR_W;
  localparam int PRE_WORDS = 64;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            req = 1'b0;
  logic            stall = 1'b0;
  logic            load_en = 1'b0;
  logic [31:0]     addr = '0;
  logic [31:0]     load_addr = '0;
  logic [31:0]     load_data = '0;

  logic [NLAT-1:0] out_ready;
  logic [NLAT-1:0] out_valid;
  logic [NLAT-1:0] out_err;
  logic [31:0]     out_inst [NLAT];

  logic [NLAT-1:0] prev_valid;
  logic [NLAT-1:0] prev_err;
  logic [31:0]     prev_inst [NLAT];

  logic [31:0]     model_mem [DEPTH];
  exp_t            sb_q [NLAT][$];
  exp_t            mon_e;
  logic            mon_adv;
  int              tick = 0;
  int              total = 0;
  int              bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NLAT; g++) begin : g_dut
    instruction_memory_pipelined #(
      .DATA_W   (32),
      .ADDR_W   (ADDR_W),
      .LATENCY  (g + 1),
      .BYTE_ADDR(1),
      .INIT_FILE("")
    ) dut (
      .in_clk         (clk),
      .in_reset_n     (reset_n),
      .in_req         (req),
      .in_addr        (addr),
      .in_stall       (stall),
      .out_req_ready  (out_ready[g]),
      .out_valid      (out_valid[g]),
      .out_instruction(out_inst[g]),
      .out_error      (out_err[g]),
      .in_load_en     (load_en),
      .in_load_addr   (load_addr),
      .in_load_data   (load_data)
    );
  end

  task automatic checkOutput(input string name, input int lat,
                             input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s lat=%0d got=%h want=%h", name, lat, actual, expected);
    end
  endtask

  // Reference behaviour: byte address, word = addr/4, bad alignment or range gives NOP + error.
  function automatic exp_t predictFetch(input logic [31:0] a, input int lat);
    exp_t e;
    e.err  = (a % 4 != 0) || (a / 4 >= DEPTH);
    e.data = e.err ? 32'h0 : model_mem[a / 4];
    e.due  = tick + lat;
    return e;
  endfunction

  // Called on a negedge; drives one cycle of inputs and returns on the next negedge.
  task automatic applyStimulus(input logic r, input logic [31:0] a, input logic s,
                               input logic le, input logic [31:0] la, input logic [31:0] ld);
    req       = r;
    addr      = a;
    stall     = s;
    load_en   = le;
    load_addr = la;
    load_data = ld;
    if (r && !s)
      for (int g = 0; g < NLAT; g++) sb_q[g].push_back(predictFetch(a, g + 1));
    if (le && la < DEPTH) model_mem[la] = ld;
    @(negedge clk);
    req     = 1'b0;
    load_en = 1'b0;
  endtask

  task automatic idle(input int n, input logic s);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, s, 1'b0, 32'h0, 32'h0);
  endtask

  // Monitor: pops the scoreboard on fresh valid outputs, checks holds during stalls.
  always @(posedge clk) begin
    mon_adv = reset_n && !stall;
    if (mon_adv) tick++;
    #1;
    for (int g = 0; g < NLAT; g++) begin
      if (reset_n) begin
        checkOutput("req_ready", g + 1, 32'(out_ready[g]), 32'(!stall));
        if (mon_adv) begin
          if (out_valid[g]) begin
            if (sb_q[g].size() == 0) begin
              checkOutput("unexpected_valid", g + 1, 32'(out_valid[g]), 32'd0);
            end else begin
              mon_e = sb_q[g].pop_front();
              checkOutput("instruction", g + 1, out_inst[g], mon_e.data);
              checkOutput("error", g + 1, 32'(out_err[g]), 32'(mon_e.err));
              checkOutput("latency_tick", g + 1, 32'(tick), 32'(mon_e.due));
            end
          end
          while (sb_q[g].size() > 0 && sb_q[g][0].due <= tick) begin
            total++;
            bad++;
            $display("[TB] FAIL missing_output lat=%0d got=no_valid want=valid_at_tick_%0d now=%0d",
                     g + 1, sb_q[g][0].due, tick);
            void'(sb_q[g].pop_front());
          end
        end else begin
          checkOutput("stall_hold_valid", g + 1, 32'(out_valid[g]), 32'(prev_valid[g]));
          checkOutput("stall_hold_inst", g + 1, out_inst[g], prev_inst[g]);
          checkOutput("stall_hold_err", g + 1, 32'(out_err[g]), 32'(prev_err[g]));
        end
      end
      prev_valid[g] = out_valid[g];
      prev_err[g]   = out_err[g];
      prev_inst[g]  = out_inst[g];
    end
  end

  initial begin
    logic [31:0] a;
    int          word;
    int          kind;

    #1;
    for (int g = 0; g < NLAT; g++) begin
      checkOutput("reset_valid", g + 1, 32'(out_valid[g]), 32'd0);
      checkOutput("reset_inst", g + 1, out_inst[g], 32'd0);
      checkOutput("reset_err", g + 1, 32'(out_err[g]), 32'd0);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] preloading %0d words", PRE_WORDS);
    for (int i = 0; i < PRE_WORDS; i++)
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'(i), (i == 1) ? 32'h0000_AAAA : $urandom);

    $display("[TB] single fetch, misaligned and out-of-range fetches");
    applyStimulus(1'b1, 32'd4, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(4, 1'b0);
    applyStimulus(1'b1, 32'd6, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'h2000, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(4, 1'b0);

    $display("[TB] back-to-back fetches with a mid-stream stall");
    applyStimulus(1'b1, 32'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'd4, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'd8, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'd12, 1'b1, 1'b0, 32'h0, 32'h0);
    idle(4, 1'b0);
    applyStimulus(1'b1, 32'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'd4, 1'b1, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'd4, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'd8, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(4, 1'b0);

    $display("[TB] read-first collision on index 3");
    applyStimulus(1'b1, 32'd12, 1'b0, 1'b1, 32'd3, 32'h0000_BBBB);
    applyStimulus(1'b1, 32'd12, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(4, 1'b0);

    $display("[TB] out-of-range load is ignored");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'(DEPTH), 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'(DEPTH + 5), 32'hFEED_F00D);
    applyStimulus(1'b1, 32'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'd20, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(4, 1'b0);

    $display("[TB] reset with fetches in flight");
    applyStimulus(1'b1, 32'd16, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 32'd20, 1'b0, 1'b0, 32'h0, 32'h0);
    #2 reset_n = 1'b0;
    #1;
    for (int g = 0; g < NLAT; g++) begin
      checkOutput("async_reset_valid", g + 1, 32'(out_valid[g]), 32'd0);
      checkOutput("async_reset_inst", g + 1, out_inst[g], 32'd0);
      checkOutput("async_reset_err", g + 1, 32'(out_err[g]), 32'd0);
      sb_q[g].delete();
    end
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, 32'd4, 1'b0, 1'b0, 32'h0, 32'h0);
    idle(5, 1'b0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 400; n++) begin
      word = $urandom_range(0, PRE_WORDS - 1);
      kind = $urandom_range(0, 9);
      if (kind < 7)      a = 32'(word * 4);
      else if (kind < 9) a = 32'(word * 4 + $urandom_range(1, 3));
      else               a = (32'($urandom_range(1, 255)) << 13) | 32'(word * 4);
      applyStimulus($urandom_range(0, 99) < 70, a, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 7) == 0,
                    ($urandom_range(0, 3) == 0) ? 32'(DEPTH + word) : 32'(word),
                    $urandom);
    end

    idle(6, 1'b0);
    for (int g = 0; g < NLAT; g++)
      checkOutput("drain_empty", g + 1, 32'(sb_q[g].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
